// File: rtl/tomasulo_issue_queue.sv
// In-order issue buffer between decode and the reservation stations, with CDB snooping.
// Optional ISSQ_CDB_FWD_EN: forward a same-cycle CDB broadcast into enqueue and onto the head outputs.
module tomasulo_issue_queue #(
  parameter int unsigned      DEPTH       = 4,
  parameter int unsigned      OP_W        = 6,
  parameter int unsigned      REG_W       = 5,
  parameter int unsigned      TAG_W       = 5,
  parameter int unsigned      DATA_W      = 32,
  parameter logic [TAG_W-1:0] INVALID_TAG = {TAG_W{1'b1}}
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_flush,
  input  logic                      in_valid,
  output logic                      out_ready,
  input  logic [OP_W-1:0]           in_operator_type,
  input  logic [REG_W-1:0]          in_reg_3,
  input  logic [DATA_W-1:0]         in_val_1,
  input  logic [DATA_W-1:0]         in_val_2,
  input  logic [TAG_W-1:0]          in_tag_1,
  input  logic [TAG_W-1:0]          in_tag_2,
  input  logic [3:0]                in_ICC_flags,
  input  logic                      in_CDB_broadcast,
  input  logic [TAG_W-1:0]          in_CDB_tag,
  input  logic [DATA_W-1:0]         in_CDB_val,
  output logic                      out_rs_valid,
  input  logic                      in_rs_ready,
  input  logic [TAG_W-1:0]          in_rs_tag,
  output logic [OP_W-1:0]           out_operator_type,
  output logic [DATA_W-1:0]         out_val_1,
  output logic [DATA_W-1:0]         out_val_2,
  output logic [TAG_W-1:0]          out_tag_1,
  output logic [TAG_W-1:0]          out_tag_2,
  output logic [3:0]                out_ICC_flags,
  output logic                      out_bank_enable,
  output logic [REG_W-1:0]          out_bank_reg,
  output logic [TAG_W-1:0]          out_bank_tag,
  output logic [$clog2(DEPTH):0]    out_count,
  output logic                      out_full,
  output logic                      out_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [OP_W-1:0]   r_op    [DEPTH];
  logic [REG_W-1:0]  r_reg3  [DEPTH];
  logic [DATA_W-1:0] r_val_1 [DEPTH];
  logic [DATA_W-1:0] r_val_2 [DEPTH];
  logic [TAG_W-1:0]  r_tag_1 [DEPTH];
  logic [TAG_W-1:0]  r_tag_2 [DEPTH];
  logic [3:0]        r_icc   [DEPTH];
  logic [DEPTH-1:0]  r_vld;

  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_bank_en;
  logic [REG_W-1:0]  r_bank_reg;
  logic [TAG_W-1:0]  r_bank_tag;

  logic              w_cdb_live;
  logic              w_stall;
  logic              w_push;
  logic              w_pop;
  logic [DATA_W-1:0] w_enq_val_1;
  logic [DATA_W-1:0] w_enq_val_2;
  logic [TAG_W-1:0]  w_enq_tag_1;
  logic [TAG_W-1:0]  w_enq_tag_2;

  // A broadcast carrying INVALID_TAG never resolves anything
  assign w_cdb_live = in_CDB_broadcast && (in_CDB_tag != INVALID_TAG);

`ifdef ISSQ_CDB_FWD_EN
  assign w_stall     = 1'b0;
  assign w_enq_val_1 = (w_cdb_live && (in_tag_1 == in_CDB_tag)) ? in_CDB_val  : in_val_1;
  assign w_enq_tag_1 = (w_cdb_live && (in_tag_1 == in_CDB_tag)) ? INVALID_TAG : in_tag_1;
  assign w_enq_val_2 = (w_cdb_live && (in_tag_2 == in_CDB_tag)) ? in_CDB_val  : in_val_2;
  assign w_enq_tag_2 = (w_cdb_live && (in_tag_2 == in_CDB_tag)) ? INVALID_TAG : in_tag_2;
`else
  // Without forwarding, an operand that would miss its broadcast is held off one cycle
  assign w_stall     = in_valid && w_cdb_live &&
                       ((in_tag_1 == in_CDB_tag) || (in_tag_2 == in_CDB_tag));
  assign w_enq_val_1 = in_val_1;
  assign w_enq_tag_1 = in_tag_1;
  assign w_enq_val_2 = in_val_2;
  assign w_enq_tag_2 = in_tag_2;
`endif

  assign out_full     = (r_count == CNT_W'(DEPTH));
  assign out_empty    = (r_count == '0);
  assign out_count    = r_count;
  assign out_ready    = !out_full && !w_stall;
  assign out_rs_valid = !out_empty;

  assign w_push = in_valid && out_ready && !in_flush;
  assign w_pop  = out_rs_valid && in_rs_ready && !in_flush;

  assign out_operator_type = r_op[r_rd_ptr];
  assign out_ICC_flags     = r_icc[r_rd_ptr];

`ifdef ISSQ_CDB_FWD_EN
  always_comb begin
    out_val_1 = r_val_1[r_rd_ptr];
    out_tag_1 = r_tag_1[r_rd_ptr];
    out_val_2 = r_val_2[r_rd_ptr];
    out_tag_2 = r_tag_2[r_rd_ptr];
    if (w_cdb_live && (r_tag_1[r_rd_ptr] == in_CDB_tag)) begin
      out_val_1 = in_CDB_val;
      out_tag_1 = INVALID_TAG;
    end
    if (w_cdb_live && (r_tag_2[r_rd_ptr] == in_CDB_tag)) begin
      out_val_2 = in_CDB_val;
      out_tag_2 = INVALID_TAG;
    end
  end
`else
  assign out_val_1 = r_val_1[r_rd_ptr];
  assign out_tag_1 = r_tag_1[r_rd_ptr];
  assign out_val_2 = r_val_2[r_rd_ptr];
  assign out_tag_2 = r_tag_2[r_rd_ptr];
`endif

  assign out_bank_enable = r_bank_en;
  assign out_bank_reg    = r_bank_reg;
  assign out_bank_tag    = r_bank_tag;

  // Pointers, occupancy, entry valid bits and the rename pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_vld      <= '0;
      r_bank_en  <= 1'b0;
      r_bank_reg <= '0;
      r_bank_tag <= '0;
    end else begin
      r_bank_en <= w_pop;
      if (w_pop) begin
        r_bank_reg <= r_reg3[r_rd_ptr];
        r_bank_tag <= in_rs_tag;
      end
      if (in_flush) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
        r_vld    <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
          r_vld[r_wr_ptr] <= 1'b1;
        end
        if (w_pop) begin
          r_rd_ptr        <= r_rd_ptr + PTR_W'(1);
          r_vld[r_rd_ptr] <= 1'b0;
        end
        r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
    end
  end

  // Entry payload: CDB snoop first, a new enqueue into the same slot overrides it
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    always_ff @(posedge clk) begin
      if (r_vld[i] && w_cdb_live && (r_tag_1[i] == in_CDB_tag)) begin
        r_val_1[i] <= in_CDB_val;
        r_tag_1[i] <= INVALID_TAG;
      end
      if (r_vld[i] && w_cdb_live && (r_tag_2[i] == in_CDB_tag)) begin
        r_val_2[i] <= in_CDB_val;
        r_tag_2[i] <= INVALID_TAG;
      end
      if (w_push && (r_wr_ptr == PTR_W'(i))) begin
        r_op[i]    <= in_operator_type;
        r_reg3[i]  <= in_reg_3;
        r_val_1[i] <= w_enq_val_1;
        r_tag_1[i] <= w_enq_tag_1;
        r_val_2[i] <= w_enq_val_2;
        r_tag_2[i] <= w_enq_tag_2;
        r_icc[i]   <= in_ICC_flags;
      end
    end
  end

endmodule

// File: tb/tb_tomasulo_issue_queue.sv
// Directed vector bench for tomasulo_issue_queue (DEPTH=4); expectations adapt to ISSQ_CDB_FWD_EN.
module tb_tomasulo_issue_queue;

`ifdef ISSQ_CDB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk, rst, in_flush, in_valid, out_ready;
  logic [5:0]  in_operator_type, out_operator_type;
  logic [4:0]  in_reg_3, in_tag_1, in_tag_2, in_CDB_tag, in_rs_tag;
  logic [31:0] in_val_1, in_val_2, in_CDB_val;
  logic [3:0]  in_ICC_flags, out_ICC_flags;
  logic        in_CDB_broadcast, out_rs_valid, in_rs_ready;
  logic [31:0] out_val_1, out_val_2;
  logic [4:0]  out_tag_1, out_tag_2, out_bank_reg, out_bank_tag;
  logic        out_bank_enable, out_full, out_empty;
  logic [2:0]  out_count;

  int n_chk  = 0;
  int n_fail = 0;

  tomasulo_issue_queue #(.DEPTH(4), .OP_W(6), .REG_W(5), .TAG_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .in_flush(in_flush), .in_valid(in_valid), .out_ready(out_ready),
    .in_operator_type(in_operator_type), .in_reg_3(in_reg_3),
    .in_val_1(in_val_1), .in_val_2(in_val_2), .in_tag_1(in_tag_1), .in_tag_2(in_tag_2),
    .in_ICC_flags(in_ICC_flags), .in_CDB_broadcast(in_CDB_broadcast),
    .in_CDB_tag(in_CDB_tag), .in_CDB_val(in_CDB_val),
    .out_rs_valid(out_rs_valid), .in_rs_ready(in_rs_ready), .in_rs_tag(in_rs_tag),
    .out_operator_type(out_operator_type), .out_val_1(out_val_1), .out_val_2(out_val_2),
    .out_tag_1(out_tag_1), .out_tag_2(out_tag_2), .out_ICC_flags(out_ICC_flags),
    .out_bank_enable(out_bank_enable), .out_bank_reg(out_bank_reg), .out_bank_tag(out_bank_tag),
    .out_count(out_count), .out_full(out_full), .out_empty(out_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
    $fatal(1);
  end

  typedef struct {
    int unsigned valid, flush, op, r3, t1, t2, v1, v2, cdb, ctag, cval, rdy, rstag;
    int unsigned e_ready, e_rsv, e_cnt, e_op, e_t1, e_t2, e_v1, e_v2, e_ben, e_breg, e_btag;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    int unsigned valid, flush, op, r3, t1, t2, v1, v2, cdb, ctag, cval, rdy, rstag,
    int unsigned e_ready, e_rsv, e_cnt, e_op, e_t1, e_t2, e_v1, e_v2, e_ben, e_breg, e_btag);
    vec_t v;
    v.valid = valid; v.flush = flush; v.op = op; v.r3 = r3; v.t1 = t1; v.t2 = t2;
    v.v1 = v1; v.v2 = v2; v.cdb = cdb; v.ctag = ctag; v.cval = cval; v.rdy = rdy; v.rstag = rstag;
    v.e_ready = e_ready; v.e_rsv = e_rsv; v.e_cnt = e_cnt; v.e_op = e_op; v.e_t1 = e_t1;
    v.e_t2 = e_t2; v.e_v1 = e_v1; v.e_v2 = e_v2; v.e_ben = e_ben; v.e_breg = e_breg; v.e_btag = e_btag;
    return v;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input int unsigned valid, flush, op, r3, t1, t2, v1, v2,
                       cdb, ctag, cval, rdy, rstag);
    in_valid         = 1'(valid);
    in_flush         = 1'(flush);
    in_operator_type = 6'(op);
    in_reg_3         = 5'(r3);
    in_tag_1         = 5'(t1);
    in_tag_2         = 5'(t2);
    in_val_1         = 32'(v1);
    in_val_2         = 32'(v2);
    in_ICC_flags     = 4'(op) ^ 4'hA;
    in_CDB_broadcast = 1'(cdb);
    in_CDB_tag       = 5'(ctag);
    in_CDB_val       = 32'(cval);
    in_rs_ready      = 1'(rdy);
    in_rs_tag        = 5'(rstag);
  endtask

  task automatic chk_state(input string nm, input int unsigned er, ersv, ecnt, eben, ebreg, ebtag);
    cmp({nm, ".ready"},    32'(out_ready),       32'(er));
    cmp({nm, ".rs_valid"}, 32'(out_rs_valid),    32'(ersv));
    cmp({nm, ".count"},    32'(out_count),       32'(ecnt));
    cmp({nm, ".full"},     32'(out_full),        32'(ecnt == 4));
    cmp({nm, ".empty"},    32'(out_empty),       32'(ecnt == 0));
    cmp({nm, ".bank_en"},  32'(out_bank_enable), 32'(eben));
    cmp({nm, ".bank_reg"}, 32'(out_bank_reg),    32'(ebreg));
    cmp({nm, ".bank_tag"}, 32'(out_bank_tag),    32'(ebtag));
  endtask

  task automatic chk_head(input string nm, input int unsigned eop, et1, et2, ev1, ev2);
    cmp({nm, ".op"},  32'(out_operator_type), 32'(eop));
    cmp({nm, ".icc"}, 32'(out_ICC_flags),     32'(4'(eop) ^ 4'hA));
    cmp({nm, ".tag1"}, 32'(out_tag_1), 32'(et1));
    cmp({nm, ".tag2"}, 32'(out_tag_2), 32'(et2));
    cmp({nm, ".val1"}, out_val_1, 32'(ev1));
    cmp({nm, ".val2"}, out_val_2, 32'(ev2));
  endtask

  initial begin
    int          mq[$];
    int unsigned m_ben, m_breg, m_btag;
    bit          iss, enq;

    // Columns: valid flush op r3 t1 t2 v1 v2 | cdb ctag cval | rdy rstag || ready rsv cnt | op t1 t2 v1 v2 | ben breg btag
    vecs.push_back(mk(1,0,'h01,4,31,31,5,7,           0,0,0,        1,9,  1,0,0, 0,0,0,0,0,             0,0,0));
    vecs.push_back(mk(0,0,0,0,31,31,0,0,              0,0,0,        1,9,  1,1,1, 'h01,31,31,5,7,        0,0,0));
    vecs.push_back(mk(0,0,0,0,31,31,0,0,              0,0,0,        0,0,  1,0,0, 0,0,0,0,0,             1,4,9));
    vecs.push_back(mk(0,0,0,0,31,31,0,0,              0,0,0,        0,0,  1,0,0, 0,0,0,0,0,             0,4,9));
    vecs.push_back(mk(1,0,'h02,1,31,31,'h20,'h21,     0,0,0,        0,0,  1,0,0, 0,0,0,0,0,             0,4,9));
    vecs.push_back(mk(1,0,'h03,2,31,31,'h30,'h31,     0,0,0,        0,0,  1,1,1, 'h02,31,31,'h20,'h21,  0,4,9));
    vecs.push_back(mk(1,0,'h04,3,31,31,'h40,'h41,     0,0,0,        0,0,  1,1,2, 'h02,31,31,'h20,'h21,  0,4,9));
    vecs.push_back(mk(1,0,'h05,4,31,31,'h50,'h51,     0,0,0,        0,0,  1,1,3, 'h02,31,31,'h20,'h21,  0,4,9));
    vecs.push_back(mk(1,0,'h06,5,31,31,'h60,'h61,     0,0,0,        0,0,  0,1,4, 'h02,31,31,'h20,'h21,  0,4,9));
    vecs.push_back(mk(0,0,0,0,31,31,0,0,              0,0,0,        1,10, 0,1,4, 'h02,31,31,'h20,'h21,  0,4,9));
    vecs.push_back(mk(0,0,0,0,31,31,0,0,              0,0,0,        0,0,  1,1,3, 'h03,31,31,'h30,'h31,  1,1,10));
    vecs.push_back(mk(0,0,0,0,31,31,0,0,              0,0,0,        0,0,  1,1,3, 'h03,31,31,'h30,'h31,  0,1,10));
    // Flush with 3 entries, a pending enqueue and a pending issue
    vecs.push_back(mk(1,1,'h07,6,31,31,'h70,'h71,     0,0,0,        1,11, 1,1,3, 'h03,31,31,'h30,'h31,  0,1,10));
    vecs.push_back(mk(0,0,0,0,31,31,0,0,              0,0,0,        0,0,  1,0,0, 0,0,0,0,0,             0,1,10));
    // CDB snoop of a queued operand; INVALID_TAG broadcast must be ignored
    vecs.push_back(mk(1,0,'h09,7,3,31,0,'h77,         0,0,0,        0,0,  1,0,0, 0,0,0,0,0,             0,1,10));
    vecs.push_back(mk(0,0,0,0,31,31,0,0,              1,3,'hDEAD,   0,0,  1,1,1, 'h09,FWD?31:3,31,FWD?'hDEAD:0,'h77, 0,1,10));
    vecs.push_back(mk(0,0,0,0,31,31,0,0,              1,31,'hBEEF,  0,0,  1,1,1, 'h09,31,31,'hDEAD,'h77, 0,1,10));
    // Enqueue colliding with a same-cycle broadcast on both operands
    vecs.push_back(mk(1,0,'h0A,8,2,2,0,0,             1,2,'hCAFE,   0,0,  FWD?1:0,1,1, 'h09,31,31,'hDEAD,'h77, 0,1,10));
    vecs.push_back(mk(FWD?0:1,0,'h0A,8,2,2,0,0,       0,0,0,        0,0,  1,1,FWD?2:1, 'h09,31,31,'hDEAD,'h77, 0,1,10));
    vecs.push_back(mk(0,0,0,0,31,31,0,0,              0,0,0,        1,12, 1,1,2, 'h09,31,31,'hDEAD,'h77, 0,1,10));
    vecs.push_back(mk(0,0,0,0,31,31,0,0,              1,2,'h1234,   0,0,  1,1,1, 'h0A,FWD?31:2,FWD?31:2,FWD?'hCAFE:0,FWD?'hCAFE:0, 1,7,12));
    vecs.push_back(mk(0,0,0,0,31,31,0,0,              0,0,0,        0,0,  1,1,1, 'h0A,31,31,FWD?'hCAFE:'h1234,FWD?'hCAFE:'h1234, 0,7,12));

    rst = 1'b1;
    drive(0,0,0,0,31,31,0,0,0,0,0,0,0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #3 chk_state("reset", 1,0,0,0,0,0);
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      string nm;
      nm = $sformatf("v%0d", i);
      drive(vecs[i].valid, vecs[i].flush, vecs[i].op, vecs[i].r3, vecs[i].t1, vecs[i].t2,
            vecs[i].v1, vecs[i].v2, vecs[i].cdb, vecs[i].ctag, vecs[i].cval,
            vecs[i].rdy, vecs[i].rstag);
      #3;
      chk_state(nm, vecs[i].e_ready, vecs[i].e_rsv, vecs[i].e_cnt,
                vecs[i].e_ben, vecs[i].e_breg, vecs[i].e_btag);
      if (vecs[i].e_rsv != 0)
        chk_head(nm, vecs[i].e_op, vecs[i].e_t1, vecs[i].e_t2, vecs[i].e_v1, vecs[i].e_v2);
      @(posedge clk); #1;
    end

    // Fill to full, then stream enqueue+issue so the pointers wrap several times
    drive(0,1,0,0,31,31,0,0,0,0,0,0,0);
    @(posedge clk); #1;
    m_ben = 0; m_breg = 7; m_btag = 12;
    for (int c = 0; c < 14; c++) begin
      string nm;
      int unsigned rdy;
      nm  = $sformatf("wrap%0d", c);
      rdy = (c >= 4) ? 1 : 0;
      drive(1,0,c+32,c,31,31,c*3,c*5+1,0,0,0,rdy,c+16);
      #3;
      chk_state(nm, (mq.size() < 4) ? 1 : 0, (mq.size() > 0) ? 1 : 0, mq.size(), m_ben, m_breg, m_btag);
      if (mq.size() > 0)
        chk_head(nm, mq[0]+32, 31, 31, mq[0]*3, mq[0]*5+1);
      iss   = (mq.size() > 0) && (rdy != 0);
      enq   = (mq.size() < 4);
      m_ben = iss ? 1 : 0;
      if (iss) begin
        m_breg = mq[0];
        m_btag = c + 16;
        void'(mq.pop_front());
      end
      if (enq) mq.push_back(c);
      @(posedge clk); #1;
    end

    // Reset while the head is being issued: no rename pulse may survive
    rst = 1'b1;
    drive(1,0,'h3F,9,31,31,1,2,0,0,0,1,20);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0,0,0,0,31,31,0,0,0,0,0,0,0);
    #3 chk_state("rst_mid", 1,0,0,0,0,0);
    @(posedge clk); #1;
    chk_state("rst_after", 1,0,0,0,0,0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
